imem_loader: RTL and testbench

//  Boot-time writer for the instruction memory that the fetch unit reads. Takes a byte

---
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time writer for the instruction memory. A byte stream arriving over a
//   valid/ready handshake is parsed as a 16-bit little-endian word count N
//   followed by 4*N data bytes. Each group of four bytes is packed
//   little-endian into a 32-bit word and written to consecutive word addresses
//   starting at 0. The core is held in reset until a complete, legal image
//   has been written.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle pulse, begins a new load (ignored while busy)
//   byte_in     in   stream byte, sampled only on a transfer
//   byte_valid  in   byte_in is valid
//   byte_ready  out  loader accepts a byte this cycle
//   mem_we      out  instruction-memory write strobe, one cycle per word
//   mem_addr    out  word address of the write (holds when mem_we=0)
//   mem_wdata   out  word to write (holds when mem_we=0)
//   core_rst    out  reset to the core, low only once the image is loaded
//   busy        out  load in progress
//   done        out  image loaded, core released
//   err         out  length header larger than DEPTH
//   words_done  out  words written in the current load
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_done
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        xfer;
  logic        start_ok;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_word;
  logic [15:0] words_inc;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;

  assign xfer      = byte_valid && byte_ready;
  assign start_ok  = start && !busy;
  assign len_word  = {byte_in, len_lo};
  assign words_inc = words_done + 16'd1;

  assign mem_we   = (state == WRITE);
  assign busy     = (state == LEN_LO) || (state == LEN_HI) ||
                    (state == DATA)   || (state == WRITE);
  assign core_rst = (state != DONE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (len_word == 16'd0)             state_next = DONE;
          else if (len_word > 16'(DEPTH))    state_next = ERR;
          else                               state_next = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && (byte_cnt == 2'd3)) state_next = WRITE;
      end
      WRITE: begin
        // words_done is 16 bits wide so the final increment to DEPTH cannot
        // overflow the comparison even when DEPTH == 2**ADDR_W.
        if (words_inc == len) state_next = DONE;
        else                  state_next = DATA;
      end
      DONE, ERR: begin
        if (start) state_next = LEN_LO;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: header capture, byte packing and write-side registers. The
  // write address/data are loaded on the fourth byte so they are stable for
  // the whole WRITE cycle and hold afterwards. words_done doubles as the word
  // index, since both advance together and are cleared together.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo     <= '0;
      len        <= '0;
      byte_cnt   <= '0;
      partial    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      words_done <= '0;
    end else begin
      if (start_ok) begin
        byte_cnt   <= '0;
        words_done <= '0;
      end
      case (state)
        LEN_LO: if (xfer) len_lo <= byte_in;
        LEN_HI: if (xfer) len <= len_word;
        DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: partial[7:0]   <= byte_in;
              2'd1: partial[15:8]  <= byte_in;
              2'd2: partial[23:16] <= byte_in;
              default: begin
                mem_wdata <= {byte_in, partial};
                mem_addr  <= words_done[ADDR_W-1:0];
              end
            endcase
          end
        end
        WRITE: words_done <= words_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       words_done;

  int checks = 0;
  int errors = 0;
  int weCount = 0;
  bit randValid = 0;
  logic [37:0] expQ[$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst(core_rst),
    .busy(busy), .done(done), .err(err), .words_done(words_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: every write strobe is matched against the oldest
  // expected (address, word) pair; a WRITE cycle must never offer ready.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [37:0] e;
      weCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", {26'd0, mem_addr}, 32'hFFFFFFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("write_addr", {26'd0, mem_addr}, {26'd0, e[37:32]});
        checkOutput("write_data", mem_wdata, e[31:0]);
      end
      checkOutput("ready_in_write", {31'd0, byte_ready}, 32'd0);
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    int budget = 0;
    bit sent = 0;
    if (randValid) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!sent && budget < 50) begin
      @(negedge clk);
      if (byte_ready) sent = 1;
      @(posedge clk); #1;
      budget++;
    end
    byte_valid = 1'b0;
    if (!sent) checkOutput("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic startPulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sendLen(input logic [15:0] n);
    applyStimulus(n[7:0]);
    applyStimulus(n[15:8]);
  endtask

  task automatic sendWord(input logic [31:0] w, input logic [5:0] addr);
    applyStimulus(w[7:0]);
    applyStimulus(w[15:8]);
    applyStimulus(w[23:16]);
    expQ.push_back({addr, w});
    applyStimulus(w[31:24]);
  endtask

  task automatic waitDone();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_we"},    {31'd0, mem_we},     32'd0);
    checkOutput({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    checkOutput({tag, "_crst"},  {31'd0, core_rst},   32'd1);
    checkOutput({tag, "_busy"},  {31'd0, busy},       32'd0);
    checkOutput({tag, "_done"},  {31'd0, done},       32'd0);
    checkOutput({tag, "_err"},   {31'd0, err},        32'd0);
    checkOutput({tag, "_words"}, {16'd0, words_done}, 32'd0);
    checkOutput({tag, "_addr"},  {26'd0, mem_addr},   32'd0);
    checkOutput({tag, "_wdata"}, mem_wdata,           32'd0);
  endtask

  initial begin
    int weBase;
    logic [31:0] w;
    rst = 1'b1; start = 1'b0; byte_in = 8'd0; byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkResetState("reset");

    // Two-word image at full rate, plus the one-cycle write latency.
    $display("[TB] full-rate two-word load");
    weBase = weCount;
    startPulse();
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    sendLen(16'd2);
    sendWord(32'h00000013, 6'd0);
    checkOutput("t1_we_latency", {31'd0, mem_we}, 32'd1);
    sendWord(32'h00100093, 6'd1);
    waitDone();
    checkOutput("t1_core_rst", {31'd0, core_rst}, 32'd0);
    checkOutput("t1_words", {16'd0, words_done}, 32'd2);
    checkOutput("t1_we_count", weCount - weBase, 32'd2);

    // Zero-length image: straight to DONE with no writes.
    $display("[TB] zero-length image");
    weBase = weCount;
    startPulse();
    checkOutput("t2_core_rst_reassert", {31'd0, core_rst}, 32'd1);
    checkOutput("t2_words_cleared", {16'd0, words_done}, 32'd0);
    sendLen(16'd0);
    checkOutput("t2_done", {31'd0, done}, 32'd1);
    checkOutput("t2_core_rst", {31'd0, core_rst}, 32'd0);
    checkOutput("t2_no_we", weCount - weBase, 32'd0);

    // Oversized header, then recovery with a legal image.
    $display("[TB] illegal length then recovery");
    weBase = weCount;
    startPulse();
    sendLen(16'(DEPTH + 1));
    checkOutput("t3_err", {31'd0, err}, 32'd1);
    checkOutput("t3_core_rst", {31'd0, core_rst}, 32'd1);
    checkOutput("t3_ready", {31'd0, byte_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 checkOutput("t3_err_hold", {31'd0, err}, 32'd1);
    checkOutput("t3_no_we", weCount - weBase, 32'd0);
    startPulse();
    checkOutput("t3_err_cleared", {31'd0, err}, 32'd0);
    sendLen(16'd1);
    sendWord(32'hDEADBEEF, 6'd0);
    waitDone();
    checkOutput("t3_words", {16'd0, words_done}, 32'd1);

    // Three words with byte_valid gaps.
    $display("[TB] random valid three-word load");
    weBase = weCount;
    randValid = 1;
    startPulse();
    sendLen(16'd3);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      sendWord(w, 6'(i));
    end
    randValid = 0;
    waitDone();
    checkOutput("t4_we_count", weCount - weBase, 32'd3);
    checkOutput("t4_words", {16'd0, words_done}, 32'd3);

    // Reset in the middle of a word discards it; reload starts at addr 0.
    $display("[TB] reset mid-word");
    startPulse();
    sendLen(16'd2);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkResetState("t5");
    startPulse();
    sendLen(16'd1);
    sendWord(32'hCAFEF00D, 6'd0);
    waitDone();

    // Full-depth image with an ignored start pulse in the middle.
    $display("[TB] full-depth load");
    weBase = weCount;
    startPulse();
    sendLen(16'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 10) begin
        startPulse();
        checkOutput("t6_busy_after_start", {31'd0, busy}, 32'd1);
      end
      w = {8'(i), 8'(~i), 16'hA55A};
      sendWord(w, 6'(i));
    end
    waitDone();
    checkOutput("t6_words", {16'd0, words_done}, 32'(DEPTH));
    checkOutput("t6_last_addr", {26'd0, mem_addr}, 32'(DEPTH - 1));
    checkOutput("t6_we_count", weCount - weBase, 32'(DEPTH));
    checkOutput("queue_empty", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
